gpioemu_bus_master: RTL and testbench
=====================================

// Module: gpioemu_bus_master
// PURPOSE
//  Bus initiator for the gpioemu multiply/popcount peripheral. One start pulse runs a full job:
//   - write A1 to 0x037F and A2 to 0x0388
//   - write control register 0x03A0 to launch the job
//   - poll status B at 0x03A0 until ready
//   - read W at 0x0390 and L at 0x0398
//  Sits between the test/host logic and the peripheral's saddress/srd/swr/sdata bus.
// PARAMETERS
//  STROBE_LEN  2    cycles srd/swr held high per access (>=1)
//  POLL_GAP    4    idle cycles after the control write, and between polls
//  MAX_POLLS   64   status reads before abort with timeout
//  RD_W_TWICE  1    1: read 0x0390 twice and keep the 2nd value (peripheral returns W one read late)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  n_reset    in   1   asynchronous active-low reset
//  start      in   1   1-cycle request; sampled only in IDLE
//  arg_a      in   24  first operand, captured on accepted start
//  arg_b      in   24  second operand, captured on accepted start
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   1-cycle pulse at job end (success or timeout)
//  result_w   out  32  W read from the peripheral; held until the next done
//  ones_l     out  24  L read from the peripheral; held until the next done
//  status_b   out  2   last B read, {ready,valid}
//  overflow   out  1   ~status_b[0], valid only when done is high and timeout=0
//  timeout    out  1   set with done when MAX_POLLS is exhausted; cleared on next start
//  saddress   out  16  bus address
//  swr        out  1   write strobe; peripheral acts on its rising edge
//  srd        out  1   read strobe; peripheral acts on its rising edge
//  sdata_out  out  32  write data to the peripheral
//  sdata_in   in   32  read data from the peripheral
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE.
//   - srd/swr drop low in the reset cycle itself, including mid-access.
//   - Captured operands and counters are cleared.
//  Bus access is one fixed sequence of STROBE_LEN+2 cycles:
//   - SETUP, 1 cycle: saddress/sdata_out driven, strobes low.
//   - STROBE, STROBE_LEN cycles: swr or srd high, never both.
//   - HOLD, 1 cycle: strobes low, address/data unchanged.
//   - Read data is sampled from sdata_in on the last STROBE cycle.
//   - saddress/sdata_out change only in SETUP.
//   - Between accesses: saddress=0, sdata_out=0.
//  State sequence:
//   IDLE -> WR_A -> WR_B -> WR_CTRL -> GAP -> POLL -> RD_W -> RD_L -> FIN -> IDLE
//   - IDLE: start=1 captures arg_a/arg_b, clears timeout, sets busy next cycle.
//   - WR_A: write 0x037F with {8'h0,arg_a}. WR_B: write 0x0388 with {8'h0,arg_b}.
//   - WR_CTRL: write 0x03A0 with 32'h0; poll counter cleared.
//   - GAP: wait POLL_GAP cycles, strobes low.
//   - POLL: read 0x03A0; status_b <= sdata_in[1:0]; poll counter +1.
//     - sdata_in[1]=1 -> RD_W.
//     - else if count==MAX_POLLS -> FIN with timeout=1, skipping W/L reads.
//     - else -> GAP.
//   - RD_W: read 0x0390, twice when RD_W_TWICE=1; result_w <= sample of the final read.
//   - RD_L: read 0x0398; ones_l <= sdata_in[23:0].
//   - FIN: done=1 and busy=0 in the same cycle; next cycle IDLE.
//     - On timeout, result_w/ones_l keep their previous values.
//  Edge cases:
//   - start while busy: ignored, no queueing.
//   - start in the FIN cycle: ignored; first acceptable start is in IDLE.
//   - Operand inputs changing during a job: no effect; captured copies are used.
//  Latency, P polls, success with RD_W_TWICE=1: 6+P accesses of (STROBE_LEN+2) cycles,
//   plus POLL_GAP*P GAP cycles, plus 1 FIN cycle.
// TESTING
//  1. arg_a=3, arg_b=5, model ready after 2 polls
//     -> writes 0x37F=3, 0x388=5, 0x3A0=0; result_w=0x0000000F, ones_l=4, overflow=0, one done pulse.
//  2. arg_a=arg_b=24'hFFFFFF -> result_w=32'hFE000001, ones_l=8, status_b=2'b10, overflow=1.
//  3. Model holds B=2'b01 forever
//     -> exactly 64 reads of 0x3A0, then done with timeout=1; result_w/ones_l unchanged.
//  4. STROBE_LEN=2 protocol check, every access exactly 4 cycles:
//     -> saddress stable SETUP..HOLD; srd/swr never both high; strobe high exactly 2 cycles.
//  5. n_reset low during the WR_B strobe -> swr low in the same cycle; all outputs 0.
//     Next start runs a clean job from WR_A.
//  6. start pulsed on cycles 1, 3 and in FIN -> only the first job runs; exactly one done.

Source files
------------

// File: rtl/gpioemu_bus_master.sv
// Bus initiator for the gpioemu multiply/popcount peripheral: writes both operands,
// launches the job, polls status until ready (or timeout), then reads W and L back.
module gpioemu_bus_master #(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned MAX_POLLS  = 64,
  parameter int unsigned RD_W_TWICE = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [23:0] arg_a,
  input  logic [23:0] arg_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_w,
  output logic [23:0] ones_l,
  output logic [1:0]  status_b,
  output logic        overflow,
  output logic        timeout,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  typedef enum logic [3:0] {IDLE, WR_A, WR_B, WR_CTRL, GAP, POLL, RD_W, RD_L, FIN} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  localparam int unsigned CNT_MAX = (STROBE_LEN > POLL_GAP) ? STROBE_LEN : POLL_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(MAX_POLLS + 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LIMIT  = PW'(MAX_POLLS);

  localparam logic [15:0] ADDR_A    = 16'h037F;
  localparam logic [15:0] ADDR_B    = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;

  state_t        state, after_access, gap_or_poll;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic          rd_second;
  logic [23:0]   op_a, op_b;
  logic [31:0]   w_hold;
  logic [23:0]   l_hold;

  function automatic logic [15:0] addr_of(state_t s);
    case (s)
      WR_A:          return ADDR_A;
      WR_B:          return ADDR_B;
      WR_CTRL, POLL: return ADDR_CTRL;
      RD_W:          return ADDR_W;
      RD_L:          return ADDR_L;
      default:       return '0;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(state_t s, logic [23:0] a, logic [23:0] b);
    case (s)
      WR_A:    return {8'h00, a};
      WR_B:    return {8'h00, b};
      default: return '0;
    endcase
  endfunction

  function automatic logic is_write(state_t s);
    return (s == WR_A) || (s == WR_B) || (s == WR_CTRL);
  endfunction

  // Successor of the access currently in its HOLD cycle; status_b is already updated here.
  always_comb begin
    gap_or_poll  = (POLL_GAP == 0) ? POLL : GAP;
    after_access = IDLE;
    case (state)
      WR_A:    after_access = WR_B;
      WR_B:    after_access = WR_CTRL;
      WR_CTRL: after_access = gap_or_poll;
      POLL: begin
        if (status_b[1])                after_access = RD_W;
        else if (poll_cnt == POLL_LIMIT) after_access = FIN;
        else                            after_access = gap_or_poll;
      end
      RD_W:    after_access = ((RD_W_TWICE != 0) && !rd_second) ? RD_W : RD_L;
      RD_L:    after_access = FIN;
      default: after_access = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      phase     <= PH_SETUP;
      cnt       <= '0;
      poll_cnt  <= '0;
      rd_second <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      w_hold    <= '0;
      l_hold    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_w  <= '0;
      ones_l    <= '0;
      status_b  <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      saddress  <= '0;
      swr       <= 1'b0;
      srd       <= 1'b0;
      sdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= arg_a;
            op_b      <= arg_b;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            state     <= WR_A;
            phase     <= PH_SETUP;
            saddress  <= ADDR_A;
            sdata_out <= {8'h00, arg_a};
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= POLL;
            phase    <= PH_SETUP;
            saddress <= ADDR_CTRL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          done     <= 1'b0;
          overflow <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          case (phase)
            PH_SETUP: begin
              phase <= PH_STROBE;
              cnt   <= '0;
              swr   <= is_write(state);
              srd   <= !is_write(state);
              if (state == POLL) poll_cnt <= poll_cnt + PW'(1);
            end
            PH_STROBE: begin
              if (cnt == STROBE_LAST) begin
                swr   <= 1'b0;
                srd   <= 1'b0;
                phase <= PH_HOLD;
                case (state)
                  POLL:    status_b <= sdata_in[1:0];
                  RD_W:    w_hold   <= sdata_in;
                  RD_L:    l_hold   <= sdata_in[23:0];
                  default: ;
                endcase
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            default: begin
              state     <= after_access;
              phase     <= PH_SETUP;
              cnt       <= '0;
              saddress  <= addr_of(after_access);
              sdata_out <= wdata_of(after_access, op_a, op_b);
              if (state == WR_CTRL) poll_cnt <= '0;
              if (state == RD_W) rd_second <= (after_access == RD_W);
              if (after_access == FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
                if (state == POLL) begin
                  timeout <= 1'b1;
                end else begin
                  result_w <= w_hold;
                  ones_l   <= l_hold;
                  overflow <= ~status_b[0];
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Randomized bench for gpioemu_bus_master against a transaction-level peripheral model
// that multiplies the written operands and serves W one read late.
module tb_gpioemu_bus_master;
  localparam int unsigned SL = 2;
  localparam int unsigned PG = 4;
  localparam int unsigned MP = 64;

  logic        clk = 1'b0;
  logic        n_reset, start;
  logic [23:0] arg_a, arg_b;
  logic        busy, done, overflow, timeout, swr, srd;
  logic [31:0] result_w, sdata_out, sdata_in;
  logic [23:0] ones_l;
  logic [1:0]  status_b;
  logic [15:0] saddress;

  always #5 clk = ~clk;

  gpioemu_bus_master #(.STROBE_LEN(SL), .POLL_GAP(PG), .MAX_POLLS(MP), .RD_W_TWICE(1)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .arg_a(arg_a), .arg_b(arg_b),
    .busy(busy), .done(done), .result_w(result_w), .ones_l(ones_l), .status_b(status_b),
    .overflow(overflow), .timeout(timeout), .saddress(saddress), .swr(swr), .srd(srd),
    .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Peripheral model
  logic [23:0] m_a1 = '0, m_a2 = '0;
  int unsigned m_ctrl_wr, m_polls, m_wreads, m_lreads, m_bad;
  int unsigned ready_after;
  bit          hang;
  logic [31:0] w_stale = 32'hBAD0_0BAD;
  logic [15:0] first_wr;
  bit          first_seen;

  always @(posedge swr) begin
    if (!first_seen) first_wr = saddress;
    first_seen = 1'b1;
    case (saddress)
      16'h037F: begin m_a1 = sdata_out[23:0]; if (sdata_out[31:24] != 0) m_bad++; end
      16'h0388: begin m_a2 = sdata_out[23:0]; if (sdata_out[31:24] != 0) m_bad++; end
      16'h03A0: begin m_ctrl_wr++; if (sdata_out != 0) m_bad++; end
      default:  m_bad++;
    endcase
  end

  always @(posedge srd) begin
    logic [47:0] prod;
    logic [31:0] r;
    prod = 48'(m_a1) * 48'(m_a2);
    r = $urandom;
    case (saddress)
      16'h03A0: begin
        m_polls++;
        if (hang) sdata_in = {r[29:0], 2'b01};
        else if (m_polls >= ready_after) sdata_in = {r[29:0], 1'b1, prod[47:32] == 0};
        else sdata_in = {r[29:0], 1'b0, r[30]};
      end
      16'h0390: begin m_wreads++; sdata_in = w_stale; w_stale = prod[31:0]; end
      16'h0398: begin m_lreads++; sdata_in = {r[7:0], 24'($countones(prod[31:0]))}; end
      default:  begin m_bad++; sdata_in = r; end
    endcase
  end

  always @(negedge srd) sdata_in = $urandom;

  // Bus protocol monitor
  int unsigned prot_err, run;
  logic [15:0] pa;
  logic [31:0] pd;
  logic        ps, s_now;
  always @(negedge clk) begin
    if (!n_reset) begin
      ps = 1'b0; run = 0;
    end else begin
      s_now = swr | srd;
      if (swr && srd) prot_err++;
      if (s_now) begin
        if (saddress !== pa || sdata_out !== pd) prot_err++;
        run++;
      end else if (ps) begin
        if (saddress !== pa || sdata_out !== pd) prot_err++;
        if (run != SL) prot_err++;
        run = 0;
      end
      pa = saddress; pd = sdata_out; ps = s_now;
    end
  end

  logic [31:0] exp_w = '0;
  logic [23:0] exp_l = '0;

  task automatic run_job(input logic [23:0] a, input logic [23:0] b, input int unsigned ra,
                         input bit hg, input bit extra_starts);
    logic [47:0] prod;
    int unsigned busy_cnt, cyc, exp_busy, exp_p, stray_busy;
    bit          valid;
    prod = 48'(a) * 48'(b);
    valid = (prod[47:32] == 0);
    exp_p = hg ? MP : ra;
    exp_busy = hg ? (3 + MP) * (SL + 2) + PG * MP : (6 + ra) * (SL + 2) + PG * ra;
    m_ctrl_wr = 0; m_polls = 0; m_wreads = 0; m_lreads = 0; m_bad = 0;
    first_seen = 1'b0; prot_err = 0; ready_after = ra; hang = hg;

    @(negedge clk); arg_a = a; arg_b = b; start = 1'b1;
    @(negedge clk); start = 1'b0; arg_a = 24'($urandom); arg_b = 24'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    check("timeout_cleared", 64'(timeout), 64'd0);
    busy_cnt = 1; cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      start = extra_starts && (cyc == 1 || cyc == 3);
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_in_fin", 64'(busy), 64'd0);
    check("latency", 64'(busy_cnt), 64'(exp_busy));
    check("timeout", 64'(timeout), 64'(hg));
    check("status_b", 64'(status_b), hg ? 64'd1 : 64'({1'b1, valid}));
    check("overflow", 64'(overflow), hg ? 64'd0 : 64'(!valid));
    if (!hg) begin exp_w = prod[31:0]; exp_l = 24'($countones(prod[31:0])); end
    check("result_w", 64'(result_w), 64'(exp_w));
    check("ones_l", 64'(ones_l), 64'(exp_l));
    check("poll_reads", 64'(m_polls), 64'(exp_p));
    check("w_reads", 64'(m_wreads), hg ? 64'd0 : 64'd2);
    check("l_reads", 64'(m_lreads), hg ? 64'd0 : 64'd1);
    check("ctrl_writes", 64'(m_ctrl_wr), 64'd1);
    check("op_a_written", 64'(m_a1), 64'(a));
    check("op_b_written", 64'(m_a2), 64'(b));
    check("first_write", 64'(first_wr), 64'h037F);
    check("bus_data_errs", 64'(m_bad), 64'd0);
    if (extra_starts) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("done_one_pulse", 64'(done), 64'd0);
    stray_busy = 0;
    repeat (3) begin @(negedge clk); if (busy || done) stray_busy++; end
    check("no_extra_job", 64'(stray_busy), 64'd0);
    check("idle_bus", {16'(saddress), 32'(sdata_out)}, 64'd0);
    check("protocol", 64'(prot_err), 64'd0);
  endtask

  task automatic reset_mid_write();
    int unsigned cyc;
    hang = 1'b0; ready_after = 1;
    @(negedge clk); arg_a = 24'($urandom); arg_b = 24'($urandom); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(swr && saddress == 16'h0388) && cyc < 200) begin @(negedge clk); cyc++; end
    check("reached_wr_b_strobe", 64'(swr && saddress == 16'h0388), 64'd1);
    #1 n_reset = 1'b0;
    #1;
    check("swr_drops_in_reset", 64'(swr), 64'd0);
    check("outputs_zero_in_reset",
          64'({busy, done, overflow, timeout, srd, status_b, ones_l}) | 64'(result_w) |
          64'({saddress, sdata_out}), 64'd0);
    @(negedge clk); @(negedge clk);
    #1 n_reset = 1'b1;
    exp_w = '0; exp_l = '0;
  endtask

  initial begin
    n_reset = 1'b0; start = 1'b0; arg_a = '0; arg_b = '0; sdata_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({busy, done, overflow, timeout, swr, srd, status_b, ones_l}) | 64'(result_w) |
          64'({saddress, sdata_out}), 64'd0);
    n_reset = 1'b1;

    run_job(24'd3, 24'd5, 2, 1'b0, 1'b0);
    run_job(24'hFFFFFF, 24'hFFFFFF, 1, 1'b0, 1'b0);
    run_job(24'($urandom), 24'($urandom), 1, 1'b1, 1'b0);
    run_job(24'd7, 24'd9, 3, 1'b0, 1'b1);
    reset_mid_write();
    run_job(24'd1234, 24'd77, 2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom); b = 24'($urandom);
      if (i % 2 == 0) begin a = a >> 12; b = b >> 8; end
      run_job(a, b, $urandom_range(1, 6), 1'b0, i % 3 == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
